cache_ctrl_param: RTL
=====================

CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning byte-address width.
REQ-002 The block SHALL have parameter IDX_W, default 5, meaning line-index width; the cache has 2^IDX_W lines.
REQ-003 The block SHALL have parameter OFF_W, default 2, meaning block-offset width; TAG_W = ADDR_W-IDX_W-OFF_W, and ADDR_W > IDX_W+OFF_W.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning performance-counter width.
REQ-005 The block SHALL have port clk  in  1  clock; all state updates occur on the rising edge.
REQ-006 The block SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have ports mem_read and mem_write  in  1  each, the CPU read and write requests; the CPU holds a request while stall=1.
REQ-008 The block SHALL have port flush  in  1  request to invalidate all lines.
REQ-009 The block SHALL have port address  in  ADDR_W  CPU byte address, split as tag[ADDR_W-1:IDX_W+OFF_W], index[IDX_W+OFF_W-1:OFF_W].
REQ-010 The block SHALL have port mem_done  in  1  main-memory completion pulse.
REQ-011 The block SHALL have port stall  out  1  freezes the CPU.
REQ-012 The block SHALL have port hit  out  1  current lookup hits.
REQ-013 The block SHALL have ports cache_rd, cache_we, refill_we  out  1  each: data-array read, write-hit update, and block fill.
REQ-014 The block SHALL have port mem_bypass  out  1  selects memory data onto the CPU read bus.
REQ-015 The block SHALL have ports mem_rd_req and mem_wr_req  out  1  each, level requests to main memory.
REQ-016 The block SHALL have port line_idx  out  IDX_W  index for the data array.
REQ-017 The block SHALL have ports hit_cnt and miss_cnt  out  CNT_W  each, saturating performance counters.

Function
REQ-018 The block SHALL hold internal valid[2^IDX_W] and tag[2^IDX_W][TAG_W]; hit = valid[index] && tag[index]==address tag, evaluated in IDLE.
REQ-019 The FSM SHALL have states IDLE, REFILL, WRITE, FLUSH; priority in IDLE is flush > mem_read > mem_write.
REQ-020 On an IDLE read hit, the block SHALL drive hit=1, cache_rd=1, stall=0, line_idx=index, stay in IDLE, and increment hit_cnt: 1-cycle latency.
REQ-021 On an IDLE read miss, the block SHALL drive stall=1 in the same cycle, latch tag and index, and enter REFILL.
REQ-022 In REFILL, the block SHALL drive mem_rd_req=1 and stall=1 until mem_done; in the mem_done cycle it SHALL drive refill_we=1, mem_bypass=1, stall=0, write tag[idx]=latched tag and valid[idx]=1 at the edge, increment miss_cnt, and return to IDLE.
REQ-023 The write policy SHALL be write-through, no-write-allocate: an IDLE write latches the address and hit status, drives stall=1, and enters WRITE.
REQ-024 In WRITE, the block SHALL drive mem_wr_req=1 and stall=1 until mem_done; in the mem_done cycle it SHALL drive stall=0, drive cache_we=1 only if the latched hit=1, increment hit_cnt or miss_cnt accordingly, and return to IDLE.
REQ-025 A write miss SHALL NOT modify tag or valid.
REQ-026 An IDLE flush SHALL enter FLUSH with stall=1, clear one valid bit per cycle from index 0 up to 2^IDX_W-1, and return to IDLE after the last index: 2^IDX_W cycles; CPU requests are ignored meanwhile.
REQ-027 When mem_read and mem_write are both high, the block SHALL service the read only; the write remains pending.
REQ-028 mem_done outside REFILL or WRITE SHALL be ignored; mem_done in the cycle of entry is impossible because requests assert only in REFILL and WRITE.
REQ-029 Counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-030 In IDLE with no request, all strobe outputs SHALL be 0, and line_idx SHALL equal the address index; outside IDLE, line_idx SHALL equal the latched or flush index.

Reset
REQ-031 Reset SHALL force state IDLE, all valid bits 0, tags 0, latched registers 0, and hit_cnt = miss_cnt = 0.
REQ-032 After reset, stall, hit, cache_rd, cache_we, refill_we, mem_bypass, mem_rd_req, and mem_wr_req SHALL be 0.
REQ-033 Reset asserted mid-REFILL, WRITE, or FLUSH SHALL abandon the operation immediately, with no valid/tag update and memory requests dropped.

Verification
REQ-034 The bench SHALL cover: after reset, read 0x084 -> stall=1, mem_rd_req=1; mem_done after 3 cycles -> refill_we=1, mem_bypass=1, stall=0; miss_cnt=1.
REQ-035 The bench SHALL cover: repeating read 0x084 -> hit=1, cache_rd=1, stall=0 same cycle; hit_cnt=1.
REQ-036 The bench SHALL cover: write 0x184 (same index, different tag) -> WRITE, mem_wr_req=1; on mem_done cache_we=0; a following read 0x084 still hits.
REQ-037 The bench SHALL cover: write 0x084 -> on mem_done cache_we=1, hit_cnt incremented.
REQ-038 The bench SHALL cover: flush with mem_read=1 -> 32 cycles stall=1; then read 0x084 misses.
REQ-039 The bench SHALL cover: reset pulsed during REFILL -> outputs 0 next sample; read 0x084 misses again; counters 0.

Source files
------------

// File: rtl/cache_ctrl_param.sv
// Direct-mapped, write-through / no-write-allocate cache controller: tag/valid
// store, refill and write-through sequencing, sequential flush, hit/miss counters.
module cache_ctrl_param #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned IDX_W  = 5,
   parameter int unsigned OFF_W  = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              flush,
   input  logic [ADDR_W-1:0] address,
   input  logic              mem_done,
   output logic              stall,
   output logic              hit,
   output logic              cache_rd,
   output logic              cache_we,
   output logic              refill_we,
   output logic              mem_bypass,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   output logic [IDX_W-1:0]  line_idx,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int unsigned LINES = 1 << IDX_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL,
      S_WRITE,
      S_FLUSH
   } state_e;

   state_e           state_q, state_d;
   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [LINES];
   logic [TAG_W-1:0] lat_tag_q, lat_tag_d;
   logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
   logic             lat_hit_q, lat_hit_d;
   logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
   logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

   logic [TAG_W-1:0] addr_tag;
   logic [IDX_W-1:0] addr_idx;
   logic             lookup_hit;
   logic             fill_c, clear_c, inc_hit_c, inc_miss_c;
   logic             unused_offset;

   // Address split; the byte offset only selects within the data block.
   assign addr_tag      = address[ADDR_W-1 -: TAG_W];
   assign addr_idx      = address[OFF_W +: IDX_W];
   assign unused_offset = ^address[OFF_W-1:0];
   assign lookup_hit    = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

   // Next-state and strobe decode.
   always_comb begin
      state_d     = state_q;
      lat_tag_d   = lat_tag_q;
      lat_idx_d   = lat_idx_q;
      lat_hit_d   = lat_hit_q;
      flush_idx_d = flush_idx_q;
      stall       = 1'b0;
      hit         = 1'b0;
      cache_rd    = 1'b0;
      cache_we    = 1'b0;
      refill_we   = 1'b0;
      mem_bypass  = 1'b0;
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      line_idx    = addr_idx;
      fill_c      = 1'b0;
      clear_c     = 1'b0;
      inc_hit_c   = 1'b0;
      inc_miss_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (flush) begin
               stall       = 1'b1;
               flush_idx_d = '0;
               state_d     = S_FLUSH;
            end else if (mem_read) begin
               hit = lookup_hit;
               if (lookup_hit) begin
                  cache_rd  = 1'b1;
                  inc_hit_c = 1'b1;
               end else begin
                  stall     = 1'b1;
                  lat_tag_d = addr_tag;
                  lat_idx_d = addr_idx;
                  state_d   = S_REFILL;
               end
            end else if (mem_write) begin
               hit       = lookup_hit;
               stall     = 1'b1;
               lat_tag_d = addr_tag;
               lat_idx_d = addr_idx;
               lat_hit_d = lookup_hit;
               state_d   = S_WRITE;
            end
         end

         S_REFILL: begin
            mem_rd_req = 1'b1;
            line_idx   = lat_idx_q;
            if (mem_done) begin
               refill_we  = 1'b1;
               mem_bypass = 1'b1;
               fill_c     = 1'b1;
               inc_miss_c = 1'b1;
               state_d    = S_IDLE;
            end else begin
               stall = 1'b1;
            end
         end

         S_WRITE: begin
            mem_wr_req = 1'b1;
            line_idx   = lat_idx_q;
            if (mem_done) begin
               cache_we   = lat_hit_q;
               inc_hit_c  = lat_hit_q;
               inc_miss_c = !lat_hit_q;
               state_d    = S_IDLE;
            end else begin
               stall = 1'b1;
            end
         end

         S_FLUSH: begin
            stall       = 1'b1;
            line_idx    = flush_idx_q;
            clear_c     = 1'b1;
            flush_idx_d = flush_idx_q + IDX_W'(1);
            if (flush_idx_q == IDX_W'(LINES - 1)) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State, tag/valid store, latches and saturating counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_q[i] <= '0;
         end
         lat_tag_q   <= '0;
         lat_idx_q   <= '0;
         lat_hit_q   <= 1'b0;
         flush_idx_q <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         lat_tag_q   <= lat_tag_d;
         lat_idx_q   <= lat_idx_d;
         lat_hit_q   <= lat_hit_d;
         flush_idx_q <= flush_idx_d;
         if (fill_c) begin
            valid_q[lat_idx_q] <= 1'b1;
            tag_q[lat_idx_q]   <= lat_tag_q;
         end
         if (clear_c) begin
            valid_q[flush_idx_q] <= 1'b0;
         end
         if (inc_hit_c && (hit_cnt_q != '1)) begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
         end
         if (inc_miss_c && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
         end
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule
